// File: rtl/mem_wb_if.sv
// Bundles the EX/MEM input slot, data-memory port and writeback bus of mem_wb_stage.
// slave = the stage itself, master = whatever drives and observes it.
interface mem_wb_if;
  logic        valid_in;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic [31:0] alu_out_in;
  logic [31:0] rdata2_in;
  logic [4:0]  rd_in;
  logic [5:0]  opcode_in;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic [31:0] wb_instr;
  logic        mem_err;

  modport slave (
    input  valid_in, instr_in, pc_in, alu_out_in, rdata2_in, rd_in, opcode_in,
    input  dmem_rdata, dmem_ack,
    output stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output wb_valid, wb_we, wb_rd, wb_data, wb_pc, wb_instr, mem_err
  );

  modport master (
    output valid_in, instr_in, pc_in, alu_out_in, rdata2_in, rd_in, opcode_in,
    output dmem_rdata, dmem_ack,
    input  stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  wb_valid, wb_we, wb_rd, wb_data, wb_pc, wb_instr, mem_err
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: issues LW/SW to data memory, retires every instruction on the wb bus.
// state  | meaning
// IDLE   | accept EX/MEM slot; non-memory and misaligned ops retire next edge
// ACCESS | memory request outstanding; waits for dmem_ack or 16-cycle timeout
module mem_wb_stage (
  input  logic     clk,
  input  logic     rst,
  mem_wb_if.slave  bus
);

  typedef enum logic [0:0] {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] wb_pc_q, wb_pc_d;
  logic [31:0] wb_instr_q, wb_instr_d;
  logic        mem_err_q, mem_err_d;
  logic        stall_c;

  logic is_sw, is_mem, no_wb, aligned;

  always_comb begin
    is_sw   = (bus.opcode_in == 6'h2B);
    is_mem  = (bus.opcode_in == 6'h23) || is_sw;
    no_wb   = (bus.opcode_in == 6'h04) || (bus.opcode_in == 6'h05) ||
              (bus.opcode_in == 6'h02);
    aligned = (bus.alu_out_in[1:0] == 2'b00);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    rd_d         = rd_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    wb_valid_d   = 1'b0;
    wb_we_d      = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    wb_pc_d      = wb_pc_q;
    wb_instr_d   = wb_instr_q;
    mem_err_d    = mem_err_q;
    stall_c      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (bus.valid_in) begin
          if (is_mem && aligned) begin
            stall_c      = 1'b1;
            dmem_req_d   = 1'b1;
            dmem_we_d    = is_sw;
            dmem_addr_d  = bus.alu_out_in;
            dmem_wdata_d = bus.rdata2_in;
            rd_d         = bus.rd_in;
            pc_d         = bus.pc_in;
            instr_d      = bus.instr_in;
            state_d      = ACCESS;
          end else begin
            wb_valid_d = 1'b1;
            wb_rd_d    = bus.rd_in;
            wb_data_d  = bus.alu_out_in;
            wb_pc_d    = bus.pc_in;
            wb_instr_d = bus.instr_in;
            if (is_mem) begin
              mem_err_d = 1'b1;
            end else begin
              wb_we_d = !no_wb && (bus.rd_in != 5'd0);
            end
          end
        end
      end
      ACCESS: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 4'd1;
        if (bus.dmem_ack || (cnt_q == 4'hF)) begin
          // A timeout also retires the slot, so upstream is released in that cycle too.
          stall_c    = 1'b0;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_pc_d    = pc_q;
          wb_instr_d = instr_q;
          if (!bus.dmem_ack) begin
            mem_err_d = 1'b1;
          end else if (!dmem_we_q) begin
            wb_data_d = bus.dmem_rdata;
            wb_we_d   = (rd_q != 5'd0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_wdata_q <= 32'd0;
      rd_q         <= 5'd0;
      pc_q         <= 32'd0;
      instr_q      <= 32'd0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= 32'd0;
      wb_pc_q      <= 32'd0;
      wb_instr_q   <= 32'd0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      rd_q         <= rd_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      wb_valid_q   <= wb_valid_d;
      wb_we_q      <= wb_we_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      wb_pc_q      <= wb_pc_d;
      wb_instr_q   <= wb_instr_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign bus.stall      = stall_c;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_we      = wb_we_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_pc      = wb_pc_q;
  assign bus.wb_instr   = wb_instr_q;
  assign bus.mem_err    = mem_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver pushes expected retirements, monitor pops on wb_valid.
module tb_mem_wb_stage;

  logic clk;
  logic rst;
  mem_wb_if bus();

  mem_wb_stage u_dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        err;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   err_model;
  int   n_cmp;
  int   n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every wb_valid pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.wb_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_wb: wb_valid=1 with empty scoreboard at %0t", $time);
        end else begin
          mon_e = sb.pop_front();
          check("wb_pc", bus.wb_pc, mon_e.pc);
          check("wb_instr", bus.wb_instr, mon_e.instr);
          check("wb_we", bus.wb_we, mon_e.we);
          check("mem_err", bus.mem_err, mon_e.err);
          if (mon_e.we) check("wb_rd", bus.wb_rd, mon_e.rd);
          if (mon_e.chk_data) check("wb_data", bus.wb_data, mon_e.data);
        end
      end
    end
  end

  task automatic scramble_inputs();
    bus.instr_in   = $urandom;
    bus.pc_in      = $urandom;
    bus.alu_out_in = $urandom;
    bus.rdata2_in  = $urandom;
    bus.rd_in      = 5'($urandom);
    bus.opcode_in  = 6'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      scramble_inputs();
      bus.valid_in   = 1'b0;
      bus.dmem_ack   = 1'($urandom_range(0, 1));
      bus.dmem_rdata = $urandom;
      @(negedge clk);
      check("stall_idle", bus.stall, 1'b0);
      check("req_idle", bus.dmem_req, 1'b0);
      @(posedge clk);
      #1;
      bus.dmem_ack = 1'b0;
    end
  endtask

  // lat = ACCESS cycle (1..16) carrying dmem_ack; anything else means memory never answers.
  task automatic issue(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] wd, input int lat, input logic [31:0] rdata);
    logic [31:0] pc;
    logic [31:0] instr;
    exp_t        e;
    bit          mem, sw, aligned, wbop;
    pc      = $urandom & 32'hFFFF_FFFC;
    instr   = {op, 26'($urandom)};
    sw      = (op == 6'h2B);
    mem     = (op == 6'h23) || sw;
    aligned = (alu[1:0] == 2'b00);
    wbop    = !mem && !(op == 6'h04 || op == 6'h05 || op == 6'h02);

    bus.valid_in   = 1'b1;
    bus.opcode_in  = op;
    bus.rd_in      = rd;
    bus.alu_out_in = alu;
    bus.rdata2_in  = wd;
    bus.pc_in      = pc;
    bus.instr_in   = instr;
    bus.dmem_ack   = 1'b0;

    e.pc = pc; e.instr = instr; e.rd = rd;
    e.we = 1'b0; e.data = 32'd0; e.chk_data = 1'b0;
    if (!mem) begin
      e.we = wbop && (rd != 5'd0);
      e.data = alu;
      e.chk_data = 1'b1;
    end else if (!aligned || lat < 1 || lat > 16) begin
      err_model = 1'b1;
    end else if (!sw) begin
      e.we = (rd != 5'd0);
      e.data = rdata;
      e.chk_data = 1'b1;
    end
    e.err = err_model;
    sb.push_back(e);

    if (!mem || !aligned) begin
      @(negedge clk);
      check("stall_pass", bus.stall, 1'b0);
      check("req_pass", bus.dmem_req, 1'b0);
      @(posedge clk);
      #1;
    end else begin
      @(negedge clk);
      check("stall_issue", bus.stall, 1'b1);
      @(posedge clk);
      #1;
      for (int k = 1; k <= 16; k++) begin
        scramble_inputs();
        bus.dmem_ack   = (k == lat);
        bus.dmem_rdata = (k == lat) ? rdata : $urandom;
        @(negedge clk);
        check("req_access", bus.dmem_req, 1'b1);
        check("addr_access", bus.dmem_addr, alu);
        check("we_access", bus.dmem_we, sw);
        check("wdata_access", bus.dmem_wdata, wd);
        if (k == lat) check("stall_ack", bus.stall, 1'b0);
        else if (k < 16) check("stall_access", bus.stall, 1'b1);
        @(posedge clk);
        #1;
        bus.dmem_ack = 1'b0;
        if (k == lat) break;
      end
      check("req_drop", bus.dmem_req, 1'b0);
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dmem_req"}, bus.dmem_req, 1'b0);
    check({tag, "_dmem_we"}, bus.dmem_we, 1'b0);
    check({tag, "_dmem_addr"}, bus.dmem_addr, 32'd0);
    check({tag, "_dmem_wdata"}, bus.dmem_wdata, 32'd0);
    check({tag, "_wb_valid"}, bus.wb_valid, 1'b0);
    check({tag, "_wb_we"}, bus.wb_we, 1'b0);
    check({tag, "_wb_data"}, bus.wb_data, 32'd0);
    check({tag, "_wb_pc"}, bus.wb_pc, 32'd0);
    check({tag, "_mem_err"}, bus.mem_err, 1'b0);
  endtask

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    logic [5:0]  op;
    logic [31:0] a;
    n_cmp = 0;
    n_err = 0;
    err_model = 1'b0;
    rst = 1'b1;
    bus.valid_in = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = 32'd0;
    scramble_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset_stall", bus.stall, 1'b0);
    rst = 1'b0;
    idle(2);

    issue(6'h00, 5'd5, 32'h10, 32'h0, 0, 32'h0);
    issue(6'h23, 5'd8, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    issue(6'h2B, 5'd9, 32'h204, 32'h55, 2, 32'h0);
    issue(6'h23, 5'd4, 32'h300, 32'h0, 16, 32'hCAFE0123);
    issue(6'h04, 5'd3, 32'h44, 32'h0, 0, 32'h0);
    issue(6'h00, 5'd0, 32'h77, 32'h0, 0, 32'h0);
    issue(6'h23, 5'd7, 32'h102, 32'h0, 1, 32'h0);
    issue(6'h23, 5'd6, 32'h400, 32'h0, 0, 32'h0);
    issue(6'h00, 5'd5, 32'h1234, 32'h0, 0, 32'h0);
    idle(2);

    // Reset while an LW sits in its 2nd ACCESS cycle.
    bus.valid_in = 1'b1;
    bus.opcode_in = 6'h23;
    bus.alu_out_in = 32'h500;
    bus.rd_in = 5'd2;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rst_pre_req", bus.dmem_req, 1'b1);
    rst = 1'b1;
    bus.valid_in = 1'b0;
    #1;
    check_all_zero("rst_access");
    err_model = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    issue(6'h00, 5'd11, 32'hABCD, 32'h0, 0, 32'h0);

    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 9);
      a = $urandom;
      if (r <= 2) op = 6'h23;
      else if (r <= 4) op = 6'h2B;
      else if (r == 5) op = ($urandom_range(0, 2) == 0) ? 6'h02 : 6'($urandom_range(4, 5));
      else begin
        op = 6'($urandom);
        if (op == 6'h23 || op == 6'h2B) op = 6'h00;
      end
      if (op == 6'h23 || op == 6'h2B) begin
        a[1:0] = 2'b00;
        if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      end
      issue(op, 5'($urandom), a, $urandom, $urandom_range(1, 18), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(3);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have one clock and one reset: clk, rst; reset is asynchronous and active-high.
REQ-002 SHALL have these ports, one per line:
- clk         in   1   clock, rising edge
- rst         in   1   async active-high reset
- valid_in    in   1   EX/MEM slot holds an instruction
- instr_in    in   32  instruction from EX/MEM
- pc_in       in   32  PC from EX/MEM
- alu_out_in  in   32  ALU result or effective address
- rdata2_in   in   32  store data
- rd_in       in   5   destination register
- opcode_in   in   6   opcode
- stall       out  1   combinational; upstream holds EX/MEM while 1
- dmem_req    out  1   data memory request, registered
- dmem_we     out  1   1 = store, 0 = load
- dmem_addr   out  32  word-aligned byte address
- dmem_wdata  out  32  store data
- dmem_rdata  in   32  load data, valid with dmem_ack
- dmem_ack    in   1   one-cycle completion pulse
- wb_valid    out  1   one-cycle pulse per retired instruction
- wb_we       out  1   register-file write enable
- wb_rd       out  5   write register
- wb_data     out  32  write data
- wb_pc       out  32  retired PC
- wb_instr    out  32  retired instruction
- mem_err     out  1   sticky error flag

Function
REQ-003 SHALL decode opcode 6'h23 as LW and 6'h2B as SW (memory ops); 6'h04, 6'h05 and 6'h02 SHALL be no-writeback; all other opcodes SHALL write alu_out_in.
REQ-004 SHALL use a two-state FSM: IDLE and ACCESS.
REQ-005 In IDLE with valid_in=1 and a non-memory op: stall=0; on the next edge, wb_valid=1, wb_data=alu_out_in, wb_rd=rd_in, and wb_pc/wb_instr are copied; latency is 1 cycle.
REQ-006 SHALL hold wb_we=1 only for writeback ops with rd≠0; otherwise wb_we=0.
REQ-007 In IDLE with valid_in=1, a memory op and alu_out_in[1:0]=0: stall=1; on the edge, latch address, wdata, rd, pc and instr; assert dmem_req=1, dmem_we=(SW); go to ACCESS.
REQ-008 In IDLE with a memory op and alu_out_in[1:0]≠0: no request; stall=0; next edge, wb_valid=1, wb_we=0, mem_err=1.
REQ-009 In ACCESS: dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL stay stable; the data inputs SHALL be ignored; stall=1 except in the dmem_ack cycle, where stall=0.
REQ-010 On dmem_ack in ACCESS: next edge, dmem_req=0, state goes to IDLE, wb_valid=1; for LW, wb_data=dmem_rdata and wb_we=(rd≠0); for SW, wb_we=0.
REQ-011 SHALL count ACCESS cycles with a 4-bit counter cleared on entry; if dmem_ack is absent in the 16th ACCESS cycle, the next edge SHALL set dmem_req=0, wb_valid=1, wb_we=0, mem_err=1 and return to IDLE.
REQ-012 If dmem_ack arrives in the 16th ACCESS cycle, ack SHALL win and no error is flagged.
REQ-013 dmem_ack seen in IDLE SHALL be ignored.
REQ-014 With valid_in=0 in IDLE: wb_valid=0 and stall=0.
REQ-015 wb_valid SHALL never be high for two cycles from one instruction.
REQ-016 mem_err SHALL stay at 1 until reset.

Reset
REQ-017 rst=1 SHALL immediately set state=IDLE, counter=0 and every registered output (dmem_*, wb_*, mem_err) to 0.
REQ-018 rst asserted during ACCESS SHALL drop dmem_req within the same cycle; no wb_valid SHALL follow for the aborted access.

Verification
REQ-019 ADD op 6'h00, rd=5, alu_out_in=0x10, valid_in=1 -> next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x10, stall=0.
REQ-020 LW addr 0x100, rd=8, dmem_ack in 3rd ACCESS cycle with rdata=0xDEADBEEF -> stall=1 for 3 cycles (0 in ack cycle); then wb_data=0xDEADBEEF, wb_we=1.
REQ-021 SW addr 0x204, rdata2_in=0x55 -> dmem_req=1, dmem_we=1, dmem_wdata=0x55 until ack; then wb_valid=1, wb_we=0.
REQ-022 LW addr 0x102 -> no dmem_req; wb_valid=1, wb_we=0, mem_err=1.
REQ-023 LW with no ack -> dmem_req high 16 cycles, then drops; mem_err=1; then an ADD retires normally.
REQ-024 Reset pulse in the 2nd ACCESS cycle -> dmem_req=0 and all outputs 0 immediately; FSM idle after deassertion.
